button_scheduler: RTL and testbench
===================================

# button_scheduler

Samples up to four raw push-buttons on a shared slow tick, debounces each one, and generates press and auto-repeat events. A round-robin arbiter serialises those events into a single valid/ready command stream. The block sits between the board buttons and the VGA drawing logic (cursor move, colour select), so that consumer sees exactly one button command per handshake.

## Interface
- `ID_W`, default 2: button index width; `N_BTN = 2**ID_W` buttons.
- `SAMPLE_DIV`, default 250000: clk cycles per sample tick, must be ≥ 2.
- `REPEAT_DELAY`, default 50: ticks from press to first repeat, must be ≥ 1.
- `REPEAT_RATE`, default 10: ticks between subsequent repeats, must be ≥ 1.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `btn` in N_BTN: raw asynchronous button levels, 1 = pressed.
- `held` out N_BTN: debounced button levels.
- `cmd_valid` out 1: a command is presented.
- `cmd_ready` in 1: the consumer accepts the command.
- `cmd_id` out ID_W: index of the button that generated the command.
- `cmd_repeat` out 1: 0 = initial press, 1 = auto-repeat.

## Operation
- **Tick counter**
  - Counts 0..SAMPLE_DIV-1 and wraps.
  - `tick` is asserted for the single cycle where count = SAMPLE_DIV-1.
- **Debounce (per button, tick cycles only)**
  - `new_level = (btn == s1) ? btn : level`, then `s1 <= btn` and `level <= new_level`.
  - `btn` is ignored outside tick cycles.
  - `held = level`.
- **Press event:** `new_level & ~level` sets `pending[i]` and clears `rep[i]`.
- **Auto-repeat (per button)**
  - A press loads `hold_cnt = REPEAT_DELAY`.
  - Each tick with `level=1` and `new_level=1` decrements `hold_cnt`.
  - When `hold_cnt` reaches 1 on a tick: set `pending[i]` and `rep[i]=1`, reload `REPEAT_RATE`.
  - Release (`new_level=0`) stops counting. It does not clear an already set `pending[i]`.
- **Event merging:** an event for button i while `pending[i]=1` is merged into it. The press type wins: `rep[i]` is cleared if either event is a press.
- **Arbiter**
  - The output register loads when `!cmd_valid || cmd_ready`.
  - Winner = first `pending` bit searching upward (wrapping) from `last+1`.
  - On load: `cmd_valid<=1`, `cmd_id<=winner`, `cmd_repeat<=rep[winner]`, `pending[winner]` cleared, `last<=winner`.
  - No pending bit at load time: `cmd_valid<=0`.
- **Simultaneous set and clear:** if a new event for button i arrives in the same cycle `pending[i]` is granted, `pending[i]` stays 1 (set wins) and `rep[i]` takes the new event's type.
- **Output stability:** `cmd_id` and `cmd_repeat` hold stable while `cmd_valid && !cmd_ready`.

## Timing
- **Reset values:** tick count 0, `s1` 0, `level`/`held` 0, `pending` 0, `rep` 0, `hold_cnt` 0, `last` = N_BTN-1 (button 0 has first priority), `cmd_valid` 0, `cmd_id` 0, `cmd_repeat` 0.
- **Press latency:** `btn` must be equal on two consecutive ticks.
  - `held` and `pending` rise in the cycle after the second tick.
  - `cmd_valid` rises one cycle later if the output register is free.
- **Release latency:** same two-tick rule.
- **Repeat spacing:** first repeat REPEAT_DELAY ticks after the press tick, then every REPEAT_RATE ticks.
- **Throughput:** one command per cycle while `cmd_ready=1`.
- **Mid-operation reset:** `rst` in any cycle clears all state on the next edge and discards an unaccepted command.
- **Backpressure:** events keep accumulating in `pending` while `cmd_ready=0`, at most one per button.

## Configuration
- **`BTN_SCHED_REPEAT_EN` defined:** auto-repeat logic is present as described.
- **`BTN_SCHED_REPEAT_EN` undefined:**
  - `hold_cnt` and `rep` are not built.
  - Only press events are generated.
  - `cmd_repeat` is tied to 0.

## Test plan
Parameters for all scenarios: ID_W=2, SAMPLE_DIV=4, REPEAT_DELAY=3, REPEAT_RATE=2, `cmd_ready=1` unless stated.

- **Reset:** assert `rst` with `btn=4'hF` → all outputs 0. The first command after release of `rst` has `cmd_id=0`.
- **Clean press:** `btn[2]=1` held across two ticks → `held[2]=1` the cycle after the second tick, then exactly one command `cmd_id=2`, `cmd_repeat=0`.
- **Bounce rejection:** `btn[1]` alternates 1/0 on successive ticks for 10 ticks → `held[1]` stays 0 and no command is issued.
- **Auto-repeat:** hold `btn[3]` for 12 ticks → press command, first repeat 3 ticks after the press tick, further repeats every 2 ticks, all with `cmd_id=3`, `cmd_repeat=1`. Without the macro, only the press command is issued.
- **Round-robin under backpressure:** with `cmd_ready=0`, press buttons 0, 1 and 3 together → when `cmd_ready=1` the ids are issued in order 0, 1, 3. `cmd_id` is stable while stalled.
- **Reset mid-stall:** a command is pending and two further buttons are pending; pulse `rst` for one cycle → `cmd_valid=0` and `pending` is empty. No stale command follows until new presses are debounced.

Source files
------------

// File: rtl/button_scheduler_if.sv
// Command stream between the button scheduler (master) and its consumer (slave).
// One command is transferred on each cycle where cmd_valid and cmd_ready are both high.
interface button_scheduler_if #(
   parameter int ID_W = 2
);
   logic            cmd_valid;
   logic            cmd_ready;
   logic [ID_W-1:0] cmd_id;
   logic            cmd_repeat;

   modport master (output cmd_valid, output cmd_id, output cmd_repeat, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_id, input cmd_repeat, output cmd_ready);
endinterface

// File: rtl/button_scheduler.sv
// Debounces up to 2**ID_W buttons on a slow tick and serialises press/auto-repeat events
// round-robin onto one valid/ready stream. Auto-repeat is built only with BTN_SCHED_REPEAT_EN.
module button_scheduler #(
   parameter int ID_W         = 2,
   parameter int SAMPLE_DIV   = 250000,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2**ID_W-1:0]  btn,
   output logic [2**ID_W-1:0]  held,
   button_scheduler_if.master  cmd
);
   localparam int N_BTN = 2**ID_W;
   localparam int CNT_W = $clog2(SAMPLE_DIV);

   if (SAMPLE_DIV < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_cfg_check
      $error("button_scheduler: illegal parameter value");
   end

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick;
   logic [N_BTN-1:0] s1_q, s1_d, level_q, level_d;
   logic [N_BTN-1:0] new_level, press_ev, rep_ev, ev;
   logic [N_BTN-1:0] pending_q, pending_d, grant;
   logic [ID_W-1:0]  last_q, last_d, cmd_id_q, cmd_id_d, winner;
   logic             cmd_valid_q, cmd_valid_d, found, load;

   always_comb begin
      tick  = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      s1_d    = tick ? btn : s1_q;
      level_d = tick ? new_level : level_q;
   end

   // A level only changes when the raw input agrees with the previous tick's sample.
   for (genvar gi = 0; gi < N_BTN; gi++) begin : g_deb
      assign new_level[gi] = (btn[gi] == s1_q[gi]) ? btn[gi] : level_q[gi];
      assign press_ev[gi]  = tick & new_level[gi] & ~level_q[gi];
   end

   assign held = level_q;

`ifdef BTN_SCHED_REPEAT_EN
   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

   logic [N_BTN-1:0] rep_q, rep_d;
   logic             cmd_repeat_q, cmd_repeat_d;

   for (genvar gi = 0; gi < N_BTN; gi++) begin : g_rep
      logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
      logic              fire;

      always_comb begin
         hold_cnt_d = hold_cnt_q;
         fire       = 1'b0;
         if (press_ev[gi]) begin
            hold_cnt_d = HOLD_W'(REPEAT_DELAY);
         end else if (tick && level_q[gi] && new_level[gi] && hold_cnt_q != '0) begin
            if (hold_cnt_q == HOLD_W'(1)) begin
               fire       = 1'b1;
               hold_cnt_d = HOLD_W'(REPEAT_RATE);
            end else begin
               hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) hold_cnt_q <= '0;
         else     hold_cnt_q <= hold_cnt_d;
      end

      assign rep_ev[gi] = fire;
   end

   // Merging into a still-queued event keeps "press" if either side is a press.
   always_comb begin
      rep_d = rep_q;
      for (int i = 0; i < N_BTN; i++) begin
         if (ev[i]) begin
            rep_d[i] = (pending_q[i] && !grant[i]) ? (rep_q[i] & rep_ev[i]) : rep_ev[i];
         end
      end
      cmd_repeat_d = cmd_repeat_q;
      if (load && found) cmd_repeat_d = rep_q[winner];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rep_q        <= '0;
         cmd_repeat_q <= 1'b0;
      end else begin
         rep_q        <= rep_d;
         cmd_repeat_q <= cmd_repeat_d;
      end
   end

   assign cmd.cmd_repeat = cmd_repeat_q;
`else
   assign rep_ev         = '0;
   assign cmd.cmd_repeat = 1'b0;
`endif

   assign ev = press_ev | rep_ev;

   always_comb begin : arb_search
      logic [ID_W-1:0] idx;
      idx    = '0;
      found  = 1'b0;
      winner = '0;
      for (int k = 1; k <= N_BTN; k++) begin
         idx = last_q + ID_W'(k);
         if (!found && pending_q[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   // A new event in the grant cycle re-arms pending: set wins over clear.
   always_comb begin
      load  = !cmd_valid_q || cmd.cmd_ready;
      grant = '0;
      if (load && found) grant[winner] = 1'b1;
      pending_d   = (pending_q & ~grant) | ev;
      cmd_valid_d = cmd_valid_q;
      cmd_id_d    = cmd_id_q;
      last_d      = last_q;
      if (load) begin
         cmd_valid_d = found;
         if (found) begin
            cmd_id_d = winner;
            last_d   = winner;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         s1_q        <= '0;
         level_q     <= '0;
         pending_q   <= '0;
         last_q      <= '1;
         cmd_valid_q <= 1'b0;
         cmd_id_q    <= '0;
      end else begin
         cnt_q       <= cnt_d;
         s1_q        <= s1_d;
         level_q     <= level_d;
         pending_q   <= pending_d;
         last_q      <= last_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_id_q    <= cmd_id_d;
      end
   end

   assign cmd.cmd_valid = cmd_valid_q;
   assign cmd.cmd_id    = cmd_id_q;
endmodule

// File: tb/tb_button_scheduler.sv
// Self-checking bench for button_scheduler: directed scenarios plus random button/ready
// activity, every cycle compared against a tick-level behavioural model.
module tb_button_scheduler;
   localparam int ID_W = 2;
   localparam int NB   = 4;
   localparam int SD   = 4;
   localparam int RD   = 3;
   localparam int RR   = 2;
`ifdef BTN_SCHED_REPEAT_EN
   localparam bit REPEAT_EN = 1'b1;
`else
   localparam bit REPEAT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [NB-1:0] btn;
   logic [NB-1:0] held;

   button_scheduler_if #(.ID_W(ID_W)) cmd_if ();

   button_scheduler #(
      .ID_W(ID_W), .SAMPLE_DIV(SD), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
   ) dut (
      .clk(clk), .rst(rst), .btn(btn), .held(held), .cmd(cmd_if.master)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int log_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // Accepted commands, one line each; entry = id + 16*repeat.
   always @(posedge clk) begin
      if (!rst && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
         log_q.push_back(int'(cmd_if.cmd_id) + (cmd_if.cmd_repeat ? 16 : 0));
         $display("cmd id=%0d repeat=%0d t=%0t", cmd_if.cmd_id, cmd_if.cmd_repeat, $time);
      end
   end

   // Behavioural model: debounced levels, ticks-since-press ages, a pending set and the output slot.
   int      m_cnt, m_last, m_id;
   int      m_age[NB];
   bit [NB-1:0] m_prev, m_level, m_pending, m_rep;
   bit      m_valid, m_rep_out;

   task automatic model_reset();
      m_cnt = 0; m_last = NB - 1; m_id = 0;
      m_prev = '0; m_level = '0; m_pending = '0; m_rep = '0;
      m_valid = 0; m_rep_out = 0;
      for (int i = 0; i < NB; i++) m_age[i] = 0;
   endtask

   task automatic model_step(input bit r, input bit [NB-1:0] b, input bit rdy);
      bit          is_tick;
      bit [NB-1:0] ev_press, ev_rep;
      int          w;
      if (r) begin
         model_reset();
         return;
      end
      is_tick  = (m_cnt == SD - 1);
      m_cnt    = is_tick ? 0 : m_cnt + 1;
      ev_press = '0;
      ev_rep   = '0;
      if (is_tick) begin
         for (int i = 0; i < NB; i++) begin
            if (b[i] == m_prev[i] && b[i] != m_level[i]) begin
               m_level[i] = b[i];
               if (b[i]) begin
                  ev_press[i] = 1;
                  m_age[i]    = 0;
               end
            end else if (m_level[i]) begin
               m_age[i]++;
               if (REPEAT_EN && m_age[i] >= RD && (m_age[i] - RD) % RR == 0) ev_rep[i] = 1;
            end
         end
         m_prev = b;
      end
      if (!m_valid || rdy) begin
         w = -1;
         for (int k = 1; k <= NB; k++)
            if (w < 0 && m_pending[(m_last + k) % NB]) w = (m_last + k) % NB;
         if (w >= 0) begin
            m_valid = 1; m_id = w; m_rep_out = m_rep[w];
            m_pending[w] = 0; m_last = w;
         end else begin
            m_valid = 0;
         end
      end
      for (int i = 0; i < NB; i++) begin
         if (ev_press[i] || ev_rep[i]) begin
            m_rep[i]     = m_pending[i] ? (m_rep[i] & ev_rep[i]) : ev_rep[i];
            m_pending[i] = 1;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step(rst, btn, cmd_if.cmd_ready);
      @(negedge clk);
      check_eq("held", held, m_level);
      check_eq("cmd_valid", cmd_if.cmd_valid, m_valid);
      if (m_valid) begin
         check_eq("cmd_id", cmd_if.cmd_id, m_id);
         check_eq("cmd_repeat", cmd_if.cmd_repeat, m_rep_out);
      end
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   initial begin
      int exp_n;
      model_reset();
      rst = 1'b1; btn = 4'hF; cmd_if.cmd_ready = 1'b1;

      // Reset with all buttons pressed, then first command must be button 0.
      run(5);
      check_eq("rst_valid", cmd_if.cmd_valid, 0);
      check_eq("rst_held", held, 0);
      check_eq("rst_id", cmd_if.cmd_id, 0);
      check_eq("rst_repeat", cmd_if.cmd_repeat, 0);
      rst = 1'b0;
      log_q.delete();
      for (int i = 0; i < 40 && log_q.size() == 0; i++) cycle();
      check_eq("first_cmd_seen", log_q.size() != 0, 1);
      if (log_q.size() != 0) check_eq("first_cmd_id", log_q[0], 0);
      btn = '0;
      run(40);

      // Clean press of button 2 across exactly two ticks.
      log_q.delete();
      btn = 4'b0100;
      run(2 * SD);
      check_eq("clean_held", held[2], 1);
      btn = '0;
      run(40);
      check_eq("clean_count", log_q.size(), 1);
      if (log_q.size() != 0) check_eq("clean_cmd", log_q[0], 2);

      // Bounce on button 1: alternating samples never settle.
      log_q.delete();
      for (int t = 0; t < 10; t++) begin
         btn = (t % 2 == 0) ? 4'b0010 : 4'b0000;
         run(SD);
         check_eq("bounce_held", held[1], 0);
      end
      btn = '0;
      run(20);
      check_eq("bounce_count", log_q.size(), 0);

      // Auto-repeat: hold button 3 for 12 ticks.
      log_q.delete();
      btn = 4'b1000;
      run(12 * SD);
      btn = '0;
      run(40);
      exp_n = REPEAT_EN ? 6 : 1;
      check_eq("repeat_count", log_q.size(), exp_n);
      foreach (log_q[i]) check_eq("repeat_cmd", log_q[i], (i == 0) ? 3 : 16 + 3);

      // Round-robin under backpressure.
      log_q.delete();
      cmd_if.cmd_ready = 1'b0;
      btn = 4'b1011;
      run(2 * SD);
      btn = '0;
      run(4 * SD);
      check_eq("stall_valid", cmd_if.cmd_valid, 1);
      check_eq("stall_id", cmd_if.cmd_id, 0);
      cmd_if.cmd_ready = 1'b1;
      run(10);
      check_eq("rr_count", log_q.size(), 3);
      if (log_q.size() == 3) begin
         check_eq("rr_0", log_q[0], 0);
         check_eq("rr_1", log_q[1], 1);
         check_eq("rr_2", log_q[2], 3);
      end

      // Reset while stalled with further buttons pending.
      cmd_if.cmd_ready = 1'b0;
      btn = 4'b0111;
      run(2 * SD);
      btn = '0;
      run(4 * SD);
      check_eq("mid_valid_before", cmd_if.cmd_valid, 1);
      rst = 1'b1;
      run(1);
      rst = 1'b0;
      check_eq("mid_valid_after", cmd_if.cmd_valid, 0);
      log_q.delete();
      cmd_if.cmd_ready = 1'b1;
      run(40);
      check_eq("mid_stale", log_q.size(), 0);

      // Random buttons, ready and rare resets.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NB; i++)
            if ($urandom_range(0, 11) == 0) btn[i] = ~btn[i];
         cmd_if.cmd_ready = ($urandom_range(0, 9) < 7);
         rst = ($urandom_range(0, 499) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
